// File: rtl/cci_multi_msg_writer_pkg.sv
// rtl/cci_multi_msg_writer_pkg.sv - CSR map, channel states and CCI-P subset types for the message writer
package cci_multi_msg_writer_pkg;

    localparam logic [15:0] CSR_DFH       = 16'h0000;
    localparam logic [15:0] CSR_AFU_ID_L  = 16'h0002;
    localparam logic [15:0] CSR_AFU_ID_H  = 16'h0004;
    localparam logic [15:0] CSR_STATUS    = 16'h0010;
    localparam logic [15:0] CSR_ADDR_BASE = 16'h0020;
    localparam logic [15:0] CSR_MSG_BASE  = 16'h0040;
    localparam logic [63:0] DFH_VALUE     = 64'h1000_0100_0000_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} t_chan_state;

    typedef struct packed {
        logic [423:0] rsvd;
        logic [7:0]   ch;
        logic [15:0]  idx;
        logic [63:0]  payload;
    } t_msg_line;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_mmio_hdr;

    typedef struct packed {
        t_ccip_c0_mmio_hdr hdr;
        logic [511:0]      data;
        logic              mmioRdValid;
        logic              mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic        format;
        logic [1:0]  cl_num;
        logic [15:0] mdata;
    } t_ccip_c1_rsp_hdr;

    typedef struct packed {
        t_ccip_c1_rsp_hdr hdr;
        logic             rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [41:0] address;
        logic        sop;
        logic [1:0]  cl_len;
        logic [15:0] mdata;
    } t_ccip_c1_req_hdr;

    typedef struct packed {
        t_ccip_c1_req_hdr hdr;
        logic [511:0]     data;
        logic             valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_hdr;

    typedef struct packed {
        t_ccip_c2_hdr hdr;
        logic [63:0]  data;
        logic         mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/cci_multi_msg_writer_if.sv
// rtl/cci_multi_msg_writer_if.sv - CCI-P Rx/Tx bundle between platform shim and AFU
interface cci_multi_msg_writer_if;
    import cci_multi_msg_writer_pkg::*;

    t_if_ccip_Rx sRx;
    t_if_ccip_Tx sTx;

    modport master (output sRx, input sTx);
    modport slave  (input sRx, output sTx);
endinterface

// File: rtl/cci_multi_msg_writer_arb.sv
// rtl/cci_multi_msg_writer_arb.sv - round-robin arbiter, search starts after the last granted requester
module cci_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt = '0;
        for (int i = N; i >= 1; i--) begin
            if (en && (((req >> ((int'(ptr_q) + i) % N)) & N'(1)) != '0)) begin
                gnt = N'(1) << ((int'(ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) ptr_d = PW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= PW'(N - 1);
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/cci_multi_msg_writer.sv
// rtl/cci_multi_msg_writer.sv - multi-channel CCI-P message writer with MMIO CSRs and response tracking
module cci_multi_msg_writer
    import cci_multi_msg_writer_pkg::*;
#(
    parameter int           NUM_CHANNELS = 4,
    parameter int           NUM_LINES    = 4,
    parameter logic [127:0] AFU_ID       = 128'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    cci_multi_msg_writer_if.slave   ccip,
    output logic [NUM_CHANNELS-1:0] busy
);
    localparam int          OW = $clog2(NUM_LINES + 1);
    localparam int          SW = OW + 3;
    localparam logic [15:0] NL = 16'(NUM_LINES);

    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;
    assign rx = ccip.sRx;

    logic        mmio_wr, status_wr;
    logic [15:0] mmio_addr;
    logic [63:0] mmio_wdata;
    assign mmio_wr    = rx.c0.mmioWrValid;
    assign mmio_addr  = rx.c0.hdr.address;
    assign mmio_wdata = rx.c0.data[63:0];
    assign status_wr  = mmio_wr && (mmio_addr == CSR_STATUS);

    logic unused_rx;
    assign unused_rx = ^{rx.c0TxAlmFull, rx.c0.data[511:64], rx.c0.hdr.length, rx.c0.hdr.rsvd};

    logic [NUM_CHANNELS-1:0] req, gnt, done_v, err_v;
    logic [41:0]             naddr_a [NUM_CHANNELS];
    logic [63:0]             pay_a   [NUM_CHANNELS];
    logic [15:0]             idx_a   [NUM_CHANNELS];

    cci_rr_arb #(.N(NUM_CHANNELS)) u_arb (
        .clk (clk),
        .rst (reset),
        .req (req),
        .en  (!rx.c1TxAlmFull),
        .gnt (gnt)
    );

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        t_chan_state   state_q, state_d;
        logic [15:0]   left_q;
        logic [41:0]   naddr_q;
        logic [63:0]   pay_q;
        logic [OW-1:0] out_q, out_d;
        logic [SW-1:0] out_sum, rsp_dec;
        logic          done_q, err_q, addr_wr, msg_wr, rsp_hit, over;

        assign addr_wr = mmio_wr && (mmio_addr == CSR_ADDR_BASE + 16'(2 * c));
        assign msg_wr  = mmio_wr && (mmio_addr == CSR_MSG_BASE + 16'(2 * c));
        assign rsp_hit = rx.c1.rspValid && (rx.c1.hdr.mdata == 16'(c));
        assign rsp_dec = !rsp_hit ? '0 :
                         rx.c1.hdr.format ? SW'(rx.c1.hdr.cl_num) + SW'(1) : SW'(1);
        // Issue and response in the same cycle net out; over-release clamps at zero.
        assign out_sum = SW'(out_q) + SW'(gnt[c]);
        assign over    = rsp_dec > out_sum;
        assign out_d   = over ? '0 : OW'(out_sum - rsp_dec);

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (addr_wr) state_d = ISSUE;
                ISSUE:   if (gnt[c] && left_q == 16'd1) state_d = DRAIN;
                DRAIN:   if (out_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) state_q <= IDLE;
            else       state_q <= state_d;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                left_q  <= '0;
                naddr_q <= '0;
                pay_q   <= '0;
                out_q   <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                out_q <= out_d;
                if (msg_wr) pay_q <= mmio_wdata;
                if (state_q == IDLE && addr_wr) begin
                    left_q  <= NL;
                    naddr_q <= mmio_wdata[41:0];
                    done_q  <= 1'b0;
                end else if (gnt[c]) begin
                    left_q  <= left_q - 16'd1;
                    naddr_q <= naddr_q + 42'd1;
                end
                if (state_q == DRAIN && out_q == '0) done_q <= 1'b1;
                if (status_wr) err_q <= 1'b0;
                if ((addr_wr && state_q != IDLE) || over) err_q <= 1'b1;
            end
        end

        assign req[c]     = (state_q == ISSUE);
        assign busy[c]    = (state_q != IDLE);
        assign done_v[c]  = done_q;
        assign err_v[c]   = err_q;
        assign naddr_a[c] = naddr_q;
        assign pay_a[c]   = pay_q;
        assign idx_a[c]   = NL - left_q;
    end

    logic [41:0] sel_addr;
    logic [63:0] sel_pay;
    logic [15:0] sel_idx;
    logic [7:0]  sel_ch;
    always_comb begin
        sel_addr = '0;
        sel_pay  = '0;
        sel_idx  = '0;
        sel_ch   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (gnt[i]) begin
                sel_addr = naddr_a[i];
                sel_pay  = pay_a[i];
                sel_idx  = idx_a[i];
                sel_ch   = 8'(i);
            end
        end
    end

    t_ccip_c1_req_hdr c1_hdr_d, c1_hdr_q;
    t_msg_line        c1_line_d, c1_line_q;
    logic             c1_valid_q;
    always_comb begin
        c1_hdr_d          = '0;
        c1_hdr_d.address  = sel_addr;
        c1_hdr_d.sop      = 1'b1;
        c1_hdr_d.mdata    = 16'(sel_ch);
        c1_line_d         = '0;
        c1_line_d.payload = sel_pay;
        c1_line_d.idx     = sel_idx;
        c1_line_d.ch      = sel_ch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c1_valid_q <= 1'b0;
            c1_hdr_q   <= '0;
            c1_line_q  <= '0;
        end else begin
            c1_valid_q <= |gnt;
            if (|gnt) begin
                c1_hdr_q  <= c1_hdr_d;
                c1_line_q <= c1_line_d;
            end
        end
    end

    logic [63:0] rd_data, rd_data_q;
    logic [8:0]  rd_tid_q;
    logic        rd_valid_q;
    always_comb begin
        rd_data = '0;
        case (mmio_addr)
            CSR_DFH:      rd_data = DFH_VALUE;
            CSR_AFU_ID_L: rd_data = AFU_ID[63:0];
            CSR_AFU_ID_H: rd_data = AFU_ID[127:64];
            CSR_STATUS:   rd_data = {40'b0, 8'(err_v), 8'(busy), 8'(done_v)};
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_tid_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rx.c0.mmioRdValid;
            if (rx.c0.mmioRdValid) begin
                rd_tid_q  <= rx.c0.hdr.tid;
                rd_data_q <= rd_data;
            end
        end
    end

    always_comb begin
        tx                = '0;
        tx.c1.valid       = c1_valid_q;
        tx.c1.hdr         = c1_hdr_q;
        tx.c1.data        = c1_line_q;
        tx.c2.mmioRdValid = rd_valid_q;
        tx.c2.hdr.tid     = rd_tid_q;
        tx.c2.data        = rd_data_q;
    end
    assign ccip.sTx = tx;
endmodule

// File: tb/tb_cci_multi_msg_writer.sv
// tb/tb_cci_multi_msg_writer.sv - directed and randomized bench for cci_multi_msg_writer
module tb_cci_multi_msg_writer;
    import cci_multi_msg_writer_pkg::*;

    localparam int           NCH = 4;
    localparam int           NL  = 4;
    localparam logic [127:0] AFU = 128'h9a1b_2c3d_4e5f_6071_8293_a4b5_c6d7_e8f9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cci_multi_msg_writer_if ccip();
    logic [NCH-1:0] busy;

    cci_multi_msg_writer #(.NUM_CHANNELS(NCH), .NUM_LINES(NL), .AFU_ID(AFU)) dut (
        .clk   (clk),
        .reset (rst),
        .ccip  (ccip),
        .busy  (busy)
    );

    t_if_ccip_c0_Rx mmio_c0 = '0;
    t_if_ccip_c1_Rx rsp_c1  = '0;
    logic           alm     = 1'b0;
    t_if_ccip_Rx    rx_s;
    always_comb begin
        rx_s             = '0;
        rx_s.c0          = mmio_c0;
        rx_s.c1          = rsp_c1;
        rx_s.c1TxAlmFull = alm;
    end
    assign ccip.sRx = rx_s;

    typedef struct {
        t_ccip_c1_req_hdr hdr;
        logic [511:0]     data;
    } t_wr;

    t_wr              wr_q[$];
    t_ccip_c1_rsp_hdr rsp_q[$];
    logic             auto_rsp = 1'b0;
    int               checks = 0;
    int               errors = 0;

    // Host side: record every write, optionally answer each with a single-line response.
    always @(negedge clk) begin
        if (ccip.sTx.c1.valid) begin
            wr_q.push_back('{hdr: ccip.sTx.c1.hdr, data: ccip.sTx.c1.data});
            if (auto_rsp) rsp_q.push_back('{format: 1'b0, cl_num: 2'd0, mdata: ccip.sTx.c1.hdr.mdata});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rsp_q.size() > 0) begin
            rsp_c1.hdr      = rsp_q.pop_front();
            rsp_c1.rspValid = 1'b1;
        end else begin
            rsp_c1 = '0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_wr(input logic [15:0] a, input logic [63:0] d);
        mmio_c0                 = '0;
        mmio_c0.mmioWrValid     = 1'b1;
        mmio_c0.hdr.address     = a;
        mmio_c0.data[63:0]      = d;
        tick();
        mmio_c0 = '0;
    endtask

    task automatic mmio_rd(input string tag, input logic [15:0] a, input logic [63:0] exp);
        logic [8:0] tid;
        tid                 = 9'($urandom);
        mmio_c0             = '0;
        mmio_c0.mmioRdValid = 1'b1;
        mmio_c0.hdr.address = a;
        mmio_c0.hdr.tid     = tid;
        tick();
        mmio_c0 = '0;
        check({tag, "_valid"}, 128'(ccip.sTx.c2.mmioRdValid), 128'(1));
        check({tag, "_tid"}, 128'(ccip.sTx.c2.hdr.tid), 128'(tid));
        check({tag, "_data"}, 128'(ccip.sTx.c2.data), 128'(exp));
        tick();
        check({tag, "_once"}, 128'(ccip.sTx.c2.mmioRdValid), 128'(0));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy != '0 && n < 400) begin
            tick();
            n++;
        end
        check(tag, 128'(busy), 128'(0));
    endtask

    task automatic wait_writes(input string tag, input int cnt);
        int n;
        n = 0;
        while (wr_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        check(tag, 128'(wr_q.size()), 128'(cnt));
    endtask

    // Reference: line i of a job goes to base+i (mod 2^42) and carries payload, i and ch.
    task automatic check_job(input int ch, input logic [41:0] base, input logic [63:0] p_old,
                             input logic [63:0] p_new, input int sw);
        int               i;
        logic [383:0]     hi;
        t_ccip_c1_req_hdr eh;
        logic [63:0]      p;
        i  = 0;
        hi = '0;
        foreach (wr_q[k]) begin
            if (wr_q[k].hdr.mdata == 16'(ch)) begin
                eh         = '0;
                eh.address = base + 42'(i);
                eh.sop     = 1'b1;
                eh.mdata   = 16'(ch);
                p          = (i < sw) ? p_old : p_new;
                check($sformatf("ch%0d_hdr%0d", ch, i), 128'(wr_q[k].hdr), 128'(eh));
                check($sformatf("ch%0d_data%0d", ch, i), wr_q[k].data[127:0],
                      {40'b0, 8'(ch), 16'(i), p});
                hi = hi | wr_q[k].data[511:128];
                i++;
            end
        end
        check($sformatf("ch%0d_lines", ch), 128'(i), 128'(NL));
        check($sformatf("ch%0d_upper", ch), 128'(|hi), 128'(0));
    endtask

    initial begin
        logic [127:0] afu_v;
        logic [63:0]  pays[NCH];
        logic [41:0]  bases[NCH];
        logic [63:0]  p_old, p_new;
        logic [41:0]  b;
        logic         seen;
        int           n_before;

        afu_v = AFU;
        repeat (3) tick();
        check("rst_c1_valid", 128'(ccip.sTx.c1.valid), 128'(0));
        check("rst_rd_valid", 128'(ccip.sTx.c2.mmioRdValid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_c0_valid", 128'(ccip.sTx.c0.valid), 128'(0));
        rst = 1'b0;
        tick();

        mmio_rd("dfh", 16'h0000, 64'h1000_0100_0000_0000);
        mmio_rd("afu_l", 16'h0002, afu_v[63:0]);
        mmio_rd("afu_h", 16'h0004, afu_v[127:64]);
        mmio_rd("status_init", 16'h0010, 64'h0);
        mmio_rd("unmapped", 16'h0006, 64'h0);

        // Single job on ch0 with first-write latency.
        auto_rsp = 1'b1;
        wr_q.delete();
        mmio_wr(16'h0040, 64'hCAFE);
        mmio_wr(16'h0020, 64'h1000);
        check("lat_t1", 128'(ccip.sTx.c1.valid), 128'(0));
        check("lat_busy", 128'(busy), 128'(1));
        tick();
        check("lat_t2", 128'(ccip.sTx.c1.valid), 128'(1));
        wait_idle("job0_idle");
        check_job(0, 42'h1000, 64'hCAFE, 64'hCAFE, NL);
        mmio_rd("status_job0", 16'h0010, 64'h1);

        // All four channels, random payloads/bases, ch3 wraps the address space.
        wr_q.delete();
        for (int c = 0; c < NCH; c++) begin
            pays[c]  = {$urandom, $urandom};
            bases[c] = 42'({$urandom, $urandom});
        end
        bases[3] = 42'h3FF_FFFF_FFFE;
        for (int c = 0; c < NCH; c++) mmio_wr(16'h0040 + 16'(2 * c), pays[c]);
        for (int c = 0; c < NCH; c++) mmio_wr(16'h0020 + 16'(2 * c), 64'(bases[c]));
        wait_idle("all_idle");
        check("all_count", 128'(wr_q.size()), 128'(NCH * NL));
        foreach (wr_q[k]) check($sformatf("rr_order%0d", k), 128'(wr_q[k].hdr.mdata), 128'(k % NCH));
        for (int c = 0; c < NCH; c++) check_job(c, bases[c], pays[c], pays[c], NL);
        mmio_rd("status_all", 16'h0010, 64'hF);

        // Almost-full hold on ch1, payload changed during the hold.
        wr_q.delete();
        p_old = {$urandom, $urandom};
        p_new = {$urandom, $urandom};
        b     = 42'({$urandom, $urandom});
        mmio_wr(16'h0042, p_old);
        mmio_wr(16'h0022, 64'(b));
        tick();
        alm  = 1'b1;
        seen = 1'b0;
        mmio_wr(16'h0042, p_new);
        seen = seen | ccip.sTx.c1.valid;
        repeat (9) begin
            tick();
            seen = seen | ccip.sTx.c1.valid;
        end
        alm = 1'b0;
        check("almfull_hold", 128'(seen), 128'(0));
        wait_idle("alm_idle");
        check_job(1, b, p_old, p_new, 1);

        // ADDR1 rewritten mid-job is ignored and flagged.
        wr_q.delete();
        b = 42'({$urandom, $urandom});
        mmio_wr(16'h0022, 64'(b));
        mmio_wr(16'h0022, 64'(b ^ 42'h5555));
        wait_idle("err_idle");
        check_job(1, b, p_new, p_new, 0);
        mmio_rd("status_err1", 16'h0010, 64'h2_000F);
        mmio_wr(16'h0010, 64'h0);
        mmio_rd("status_clr", 16'h0010, 64'hF);

        // ch2 completed by one multi-line response.
        auto_rsp = 1'b0;
        wr_q.delete();
        b = 42'({$urandom, $urandom});
        mmio_wr(16'h0024, 64'(b));
        wait_writes("fmt_writes", NL);
        tick();
        check("fmt_drain_busy", 128'(busy), 128'(4'b0100));
        rsp_q.push_back('{format: 1'b1, cl_num: 2'd3, mdata: 16'd2});
        wait_idle("fmt_idle");
        check_job(2, b, pays[2], pays[2], NL);
        mmio_rd("status_fmt", 16'h0010, 64'hF);

        // Reset mid-job on ch3, then a stale response.
        wr_q.delete();
        b = 42'({$urandom, $urandom});
        mmio_wr(16'h0026, 64'(b));
        tick();
        rst = 1'b1;
        #1;
        check("midrst_c1_valid", 128'(ccip.sTx.c1.valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        n_before = wr_q.size();
        repeat (2) tick();
        rsp_q.delete();
        rst = 1'b0;
        tick();
        mmio_rd("status_rst", 16'h0010, 64'h0);
        rsp_q.push_back('{format: 1'b0, cl_num: 2'd0, mdata: 16'd3});
        repeat (5) tick();
        check("no_wr_after_rst", 128'(wr_q.size()), 128'(n_before));
        mmio_rd("status_late", 16'h0010, 64'h8_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
